// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo: buffered character UART on the CSR bus.
//
// Two CSRs:
//   BASE_ADDR   data/status: read = {tx_idle, rx_overrun, tx_full, rx_empty, rx_head[7:0]}
//                 write (001) pushes wdata[7:0] to TX, set (010) pops RX,
//                 clear (011) with wdata[10]=1 clears rx_overrun.
//   BASE_ADDR+1 control: [15:0] divisor, [16] rxie, [17] txie (write/set/clear bitwise).
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   read               CSR read strobe (unused: reads have no side effects)
//   modify[2:0]        E-stage write code: 001 write, 010 set, 011 clear
//   wdata[31:0]        E-stage write data
//   addr[11:0]         D-stage CSR address
//   rdata[31:0], valid registered E-stage read result (0 / 0 when not addressed)
//   rx                 asynchronous serial input
//   tx                 serial output (idle high)
//   irq                level interrupt
//
// CSR handshake: addr is presented in cycle N (D stage); modify/wdata are
// presented in cycle N+1 (E stage); at the end of cycle N+1 the write is
// applied and valid/rdata capture the pre-write register value, so they are
// visible throughout cycle N+2 only.
module csr_uart_fifo #(
    parameter logic [11:0] BASE_ADDR  = 12'hBC0,
    parameter int          CLOCK_RATE = 12_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          TX_DEPTH   = 8,
    parameter int          RX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int          TAW       = $clog2(TX_DEPTH);
    localparam int          RAW       = $clog2(RX_DEPTH);
    localparam logic [15:0] DIV_RESET = 16'(CLOCK_RATE / BAUD_RATE);
    localparam logic [2:0]  MOD_WRITE = 3'b001;
    localparam logic [2:0]  MOD_SET   = 3'b010;
    localparam logic [2:0]  MOD_CLEAR = 3'b011;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic unused_inputs;
    assign unused_inputs = ^{read, wdata[31:18]};

    // ---------------- CSR decode and control register ----------------
    logic        en_data, en_ctrl;
    logic [15:0] divisor;
    logic        rxie, txie;
    logic [17:0] ctrl_cur, ctrl_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_data <= 1'b0;
            en_ctrl <= 1'b0;
        end else begin
            en_data <= (addr == BASE_ADDR);
            en_ctrl <= (addr == BASE_ADDR + 12'd1);
        end
    end

    assign ctrl_cur = {txie, rxie, divisor};

    always_comb begin
        ctrl_next = ctrl_cur;
        case (modify)
            MOD_WRITE: ctrl_next = wdata[17:0];
            MOD_SET:   ctrl_next = ctrl_cur | wdata[17:0];
            MOD_CLEAR: ctrl_next = ctrl_cur & ~wdata[17:0];
            default:   ctrl_next = ctrl_cur;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {txie, rxie, divisor} <= {2'b00, DIV_RESET};
        end else if (en_ctrl) begin
            {txie, rxie, divisor} <= ctrl_next;
        end
    end

    // Bit period is clamped so the RX half-period count never collapses.
    logic [15:0] bit_period, reload, half_reload;
    assign bit_period  = (divisor < 16'd4) ? 16'd4 : divisor;
    assign reload      = bit_period - 16'd1;
    assign half_reload = (bit_period >> 1) - 16'd1;

    logic tx_push, rx_pop, ovr_clr;
    assign tx_push = en_data && (modify == MOD_WRITE);
    assign ovr_clr = en_data && (modify == MOD_CLEAR) && wdata[10];

    // ---------------- TX FIFO ----------------
    logic [7:0] tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;
    logic tx_empty, tx_full, tx_pop, tx_wr;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
    assign tx_wr    = tx_push && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wp[TAW-1:0]] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_wr)  tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
        end
    end

    // ---------------- TX shifter ----------------
    // The line flop follows the shifter one cycle later, so a frame that ends
    // and the next one that loads on the same edge stay gapless on the wire.
    logic       tx_busy;
    logic [9:0] tx_shift;
    logic [3:0] tx_bit;
    logic [15:0] tx_cnt;
    logic       tx_frame_end;

    assign tx_frame_end = tx_busy && (tx_cnt == 16'd0) && (tx_bit == 4'd9);
    assign tx_pop       = !tx_empty && (!tx_busy || tx_frame_end);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_busy  <= 1'b0;
            tx_shift <= 10'h3FF;
            tx_bit   <= 4'd0;
            tx_cnt   <= 16'd0;
            tx       <= 1'b1;
        end else begin
            tx <= tx_busy ? tx_shift[0] : 1'b1;
            if (tx_pop) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, tx_mem[tx_rp[TAW-1:0]], 1'b0};
                tx_bit   <= 4'd0;
                tx_cnt   <= reload;
            end else if (tx_busy) begin
                if (tx_cnt == 16'd0) begin
                    if (tx_bit == 4'd9) begin
                        tx_busy <= 1'b0;
                    end else begin
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_bit   <= tx_bit + 4'd1;
                        tx_cnt   <= reload;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // ---------------- RX synchronizer and FSM ----------------
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_byte;
    logic        rx_done;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_byte  <= 8'd0;
            rx_done  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= half_reload;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        // A high line at mid start bit is a glitch, not a frame.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        rx_cnt   <= reload;
                        rx_bit   <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        rx_cnt  <= reload;
                        rx_bit  <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == 16'd0) begin
                        rx_done  <= rx_s;   // stop bit 0 = framing error, byte dropped
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0] rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wp, rx_rp;
    logic rx_empty, rx_full, rx_wr, rx_ovr;
    logic [7:0] rx_head;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
    assign rx_pop   = en_data && (modify == MOD_SET) && !rx_empty;
    assign rx_wr    = rx_done && (!rx_full || rx_pop);
    assign rx_head  = rx_empty ? 8'd0 : rx_mem[rx_rp[RAW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp[RAW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_ovr <= 1'b0;
        end else begin
            if (rx_wr)  rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (rx_done && !rx_wr) rx_ovr <= 1'b1;
            else if (ovr_clr)      rx_ovr <= 1'b0;
        end
    end

    // ---------------- Read path and interrupt ----------------
    logic        tx_idle;
    logic [31:0] data_word, ctrl_word;

    assign tx_idle   = tx_empty && !tx_busy;
    assign data_word = {20'd0, tx_idle, rx_ovr, tx_full, rx_empty, rx_head};
    assign ctrl_word = {14'd0, ctrl_cur};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            rdata <= 32'd0;
            irq   <= 1'b0;
        end else begin
            valid <= en_data || en_ctrl;
            rdata <= en_data ? data_word : (en_ctrl ? ctrl_word : 32'd0);
            irq   <= (rxie && !rx_empty) || (txie && tx_empty);
        end
    end
endmodule

// File: tb/tb_csr_uart_fifo.sv
module tb_csr_uart_fifo;
    localparam logic [11:0] DATA_A = 12'hBC0;
    localparam logic [11:0] CTRL_A = 12'hBC1;

    logic        clk, rstn, read, rx, tx, irq, valid;
    logic [2:0]  modify;
    logic [31:0] wdata, rdata;
    logic [11:0] addr;

    logic [31:0] exp_q[$];     // expected CSR read results (pre-write values)
    logic [7:0]  tx_exp_q[$];  // expected bytes on the tx line
    int checks, errors;
    int tb_d;
    logic gap_check;

    csr_uart_fifo #(
        .BASE_ADDR(12'hBC0), .CLOCK_RATE(1_600_000), .BAUD_RATE(100_000),
        .TX_DEPTH(8), .RX_DEPTH(8)
    ) dut (
        .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
        .addr(addr), .rdata(rdata), .valid(valid), .rx(rx), .tx(tx), .irq(irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the E-stage edge.
    task automatic csr_op(input logic [11:0] a, input logic [2:0] m,
                          input logic [31:0] wd, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr = a; read = (m == 3'b000); modify = 3'b000;
        @(negedge clk);
        addr = 12'h000; read = 1'b0; modify = m; wdata = wd;
        @(negedge clk);
        modify = 3'b000; wdata = 32'd0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            repeat (tb_d) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // ---------------- scoreboard: CSR read monitor ----------------
    initial begin : csr_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL csr_unexpected got %h want none", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        errors++;
                        $display("FAIL csr_read got %h want %h", rdata, e);
                    end
                end
            end
        end
    end

    // ---------------- scoreboard: tx line monitor ----------------
    // Checks every cycle of each frame against the expected level.
    initial begin : tx_mon
        logic [9:0] fr;
        logic [7:0] b;
        logic aborted;
        int d, bad, first_bad;
        @(negedge clk);
        forever begin
            while (tx !== 1'b0) @(negedge clk);
            d = tb_d;
            if (tx_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected got frame want none");
                b = 8'h00;
            end else begin
                b = tx_exp_q.pop_front();
            end
            fr = {1'b1, b, 1'b0};
            bad = 0; first_bad = 0; aborted = 1'b0;
            for (int i = 0; i < 10 * d; i++) begin
                if (!rstn) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== fr[i / d]) begin
                    if (bad == 0) first_bad = i;
                    bad++;
                end
                @(negedge clk);
            end
            if (!aborted) begin
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL tx_frame byte %h got %0d bad cycles (first %0d) want 0", b, bad, first_bad);
                end
                if (gap_check && tx_exp_q.size() > 0) begin
                    checks++;
                    if (tx !== 1'b0) begin
                        errors++;
                        $display("FAIL tx_gap got %b want 0", tx);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0; tb_d = 16; gap_check = 1'b0;
        rstn = 1'b0; rx = 1'b1; read = 1'b0; modify = 3'b000; wdata = 32'd0; addr = 12'h000;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);
        csr_op(CTRL_A, 3'b000, 32'd0, 32'h10);

        // 1: single byte 0x55
        tx_exp_q.push_back(8'h55);
        csr_op(DATA_A, 3'b001, 32'h55, 32'h900);
        repeat (170) @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);

        // 2: ten back-to-back writes, the tenth is dropped
        gap_check = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 9) tx_exp_q.push_back(8'(k));
            csr_op(DATA_A, 3'b001, 32'(k), (k == 1) ? 32'h900 : (k == 10) ? 32'h300 : 32'h100);
        end
        csr_op(DATA_A, 3'b000, 32'd0, 32'h300);
        repeat (1500) @(negedge clk);
        gap_check = 1'b0;
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);

        // 3: receive 0xA3 with rxie
        csr_op(CTRL_A, 3'b001, 32'h10010, 32'h10);
        send_rx(8'hA3, 1'b1);
        chk("irq_rx", {31'd0, irq}, 32'd1);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h8A3);
        csr_op(DATA_A, 3'b010, 32'd1, 32'h8A3);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_drop", {31'd0, irq}, 32'd0);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);

        // 4: nine frames into an 8-deep FIFO -> overrun
        for (int k = 0; k < 9; k++) send_rx(8'(8'h10 + k), 1'b1);
        chk("irq_full", {31'd0, irq}, 32'd1);
        csr_op(DATA_A, 3'b000, 32'd0, 32'hC10);
        for (int k = 0; k < 8; k++) csr_op(DATA_A, 3'b010, 32'd1, 32'hC10 + 32'(k));
        csr_op(DATA_A, 3'b000, 32'd0, 32'hD00);
        chk("irq_empty", {31'd0, irq}, 32'd0);
        csr_op(DATA_A, 3'b011, 32'h400, 32'hD00);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);

        // 5: start-bit glitch and framing error
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);
        send_rx(8'h5A, 1'b0);
        repeat (40) @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);

        // 6: divisor 8, divisor 2 (clamped to 4), reset mid-frame
        csr_op(CTRL_A, 3'b001, 32'h8, 32'h10010);
        tb_d = 8;
        tx_exp_q.push_back(8'h00);
        csr_op(DATA_A, 3'b001, 32'h00, 32'h900);
        repeat (100) @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);
        csr_op(CTRL_A, 3'b001, 32'h2, 32'h8);
        tb_d = 4;
        csr_op(CTRL_A, 3'b000, 32'd0, 32'h2);
        tx_exp_q.push_back(8'hC3);
        csr_op(DATA_A, 3'b001, 32'hC3, 32'h900);
        repeat (60) @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);
        tx_exp_q.push_back(8'h5A);
        csr_op(DATA_A, 3'b001, 32'h5A, 32'h900);
        csr_op(DATA_A, 3'b001, 32'h66, 32'h100);
        csr_op(DATA_A, 3'b001, 32'h77, 32'h100);
        repeat (4) @(negedge clk);
        chk("tx_midframe", {31'd0, tx}, 32'd0);
        #2 rstn = 1'b0;
        #1 chk("tx_async_reset", {31'd0, tx}, 32'd1);
        tx_exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        tb_d = 16;
        @(negedge clk);
        csr_op(DATA_A, 3'b000, 32'd0, 32'h900);
        csr_op(CTRL_A, 3'b000, 32'd0, 32'h10);
        repeat (30) @(negedge clk);
        chk("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        repeat (5) @(negedge clk);
        chk("csr_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
